// File: rtl/poci_gpio.sv
// poci_gpio: POCI GPIO slave with synchronised, debounced inputs,
// sticky rise/fall flags, a level irq and set/clear outputs.
// Ports: pclk/presetn (sync, active low), POCI psel/penable/pwrite/
// paddr/pwdata/prdata/pready/pslverr, gpio_in[NIN], gpio_out[NOUT], irq.
// Option: define POCI_GPIO_INVERT_EN to add INV (0x1C), XORed into gpio_in.
module poci_gpio #(
  parameter int NIN             = 14,
  parameter int NOUT            = 18,
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic            pclk,
  input  logic            presetn,
  input  logic            psel,
  input  logic            penable,
  input  logic            pwrite,
  input  logic [4:0]      paddr,
  input  logic [31:0]     pwdata,
  output logic [31:0]     prdata,
  output logic            pready,
  output logic            pslverr,
  input  logic [NIN-1:0]  gpio_in,
  output logic [NOUT-1:0] gpio_out,
  output logic            irq
);

  localparam int PW = $clog2(DEBOUNCE_CYCLES);

  localparam logic [2:0] A_IN   = 3'd0;
  localparam logic [2:0] A_RISE = 3'd1;
  localparam logic [2:0] A_FALL = 3'd2;
  localparam logic [2:0] A_OUT  = 3'd3;
  localparam logic [2:0] A_SET  = 3'd4;
  localparam logic [2:0] A_CLR  = 3'd5;
  localparam logic [2:0] A_EN   = 3'd6;
  localparam logic [2:0] A_INV  = 3'd7;

  logic [NIN-1:0]  sync0_q, sync1_q, samp_q, state_q;
  logic [NIN-1:0]  rise_q, fall_q, en_q, inv_q;
  logic [NIN-1:0]  samp_d, state_d, rise_d, fall_d, en_d, inv_d;
  logic [NIN-1:0]  in_x, upd, wdi;
  logic [NOUT-1:0] out_q, out_d, wdo;
  logic [PW-1:0]   presc_q, presc_d;
  logic            irq_q, irq_d, tick;
  logic [2:0]      idx;
  logic            access, hit, err, wr;
  logic [31:0]     rdata;
  logic            unused_bits;

  assign unused_bits = ^{paddr[1:0], pwdata};

  assign idx    = paddr[4:2];
  assign access = psel & penable;
  assign wdi    = pwdata[NIN-1:0];
  assign wdo    = pwdata[NOUT-1:0];

`ifdef POCI_GPIO_INVERT_EN
  assign in_x = gpio_in ^ inv_q;
`else
  assign in_x = gpio_in;
`endif

  always_comb begin
    rdata = '0;
    hit   = 1'b1;
    unique case (idx)
      A_IN:   rdata = 32'(state_q);
      A_RISE: rdata = 32'(rise_q);
      A_FALL: rdata = 32'(fall_q);
      A_OUT:  rdata = 32'(out_q);
      A_SET:  rdata = '0;
      A_CLR:  rdata = '0;
      A_EN:   rdata = 32'(en_q);
      A_INV: begin
`ifdef POCI_GPIO_INVERT_EN
        rdata = 32'(inv_q);
`else
        hit   = 1'b0;
`endif
      end
    endcase
  end

  assign prdata  = psel ? rdata : '0;
  assign pready  = 1'b1;
  assign err     = access & (~hit | (pwrite & (idx == A_IN)));
  assign pslverr = err;
  assign wr      = access & pwrite & ~err;

  // A channel moves only when two successive ticks saw the same value.
  assign tick    = (presc_q == PW'(DEBOUNCE_CYCLES - 1));
  assign presc_d = tick ? '0 : presc_q + PW'(1);
  assign samp_d  = tick ? sync1_q : samp_q;
  assign upd     = tick ? (~(sync1_q ^ samp_q) & (sync1_q ^ state_q)) : '0;
  assign state_d = state_q ^ upd;

  // Hardware set is ORed in after the clear, so it wins a collision.
  always_comb begin
    rise_d = rise_q;
    fall_d = fall_q;
    en_d   = en_q;
    inv_d  = inv_q;
    out_d  = out_q;
    if (wr && idx == A_RISE) rise_d = rise_d & ~wdi;
    if (wr && idx == A_FALL) fall_d = fall_d & ~wdi;
    if (wr && idx == A_EN)   en_d   = wdi;
`ifdef POCI_GPIO_INVERT_EN
    if (wr && idx == A_INV)  inv_d  = wdi;
`endif
    if (wr && idx == A_OUT)  out_d  = wdo;
    if (wr && idx == A_SET)  out_d  = out_q | wdo;
    if (wr && idx == A_CLR)  out_d  = out_q & ~wdo;
    rise_d = rise_d | (upd & sync1_q);
    fall_d = fall_d | (upd & ~sync1_q);
  end

  assign irq_d = |((rise_q | fall_q) & en_q);

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      sync0_q <= '0;
      sync1_q <= '0;
      samp_q  <= '0;
      state_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      en_q    <= '0;
      inv_q   <= '0;
      out_q   <= '0;
      presc_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      sync0_q <= in_x;
      sync1_q <= sync0_q;
      samp_q  <= samp_d;
      state_q <= state_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      en_q    <= en_d;
      inv_q   <= inv_d;
      out_q   <= out_d;
      presc_q <= presc_d;
      irq_q   <= irq_d;
    end
  end

  assign gpio_out = out_q;
  assign irq      = irq_q;

endmodule
